fifo_rd_cntrl: RTL and testbench

FIFO_RD_CNTRL -- requirements
Module: fifo_rd_cntrl

---
 rtl/fifo_rd_cntrl_if.sv | 28 ++
 rtl/fifo_rd_cntrl.sv | 115 +++++++++++
 tb/tb_fifo_rd_cntrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_cntrl_if.sv
// Read-side FIFO controller bus: write-pointer input, memory read port,
// status outputs and the valid/ready output stream.
interface fifo_rd_cntrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  logic [DEPTH:0]   rq_wptr;
  logic [WIDTH-1:0] rdata;
  logic [DEPTH-1:0] raddr;
  logic [DEPTH:0]   rptr;
  logic             rempty;
  logic [DEPTH:0]   rcount;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  // Controller view
  modport slave (
    input  rq_wptr, rdata, out_ready,
    output raddr, rptr, rempty, rcount, out_data, out_valid
  );

  // Environment view (write side, memory and sink)
  modport master (
    output rq_wptr, rdata, out_ready,
    input  raddr, rptr, rempty, rcount, out_data, out_valid
  );
endinterface

// File: rtl/fifo_rd_cntrl.sv
// Read-side controller of an asynchronous FIFO.
// Keeps the binary/gray read pointer, the registered empty flag and word
// count, and a one-entry output register with valid/ready handshake.
// Optional macro FIFO_RD_SYNC_EN: pass the write gray pointer through a
// 2-flop synchronizer in the read clock domain before using it.
module fifo_rd_cntrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic               rclk,
  input  logic               rrst,
  fifo_rd_cntrl_if.slave     bus
);

  localparam int PW = DEPTH + 1;

  // Gray to binary: each binary bit is the XOR of all gray bits above and at it
  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  logic [PW-1:0]    r_rbin;
  logic [PW-1:0]    r_rptr;
  logic             r_rempty;
  logic [PW-1:0]    r_rcount;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;

  logic             w_pop;
  logic [PW-1:0]    w_rbin_next;
  logic [PW-1:0]    w_rgnext;
  logic [PW-1:0]    w_wsync;

`ifdef FIFO_RD_SYNC_EN
  logic [PW-1:0]    r_sync1;
  logic [PW-1:0]    r_sync2;

  // Two-stage synchronizer bringing the write gray pointer into rclk
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_sync1 <= {PW{1'b0}};
      r_sync2 <= {PW{1'b0}};
    end else begin
      r_sync1 <= bus.rq_wptr;
      r_sync2 <= r_sync1;
    end
  end

  assign w_wsync = r_sync2;
`else
  // Write side already delivers a pointer synchronized to rclk
  assign w_wsync = bus.rq_wptr;
`endif

  // Pop whenever a word is stored and the output register is free or draining
  always_comb begin
    w_pop = 1'b0;
    if (!rrst && !r_rempty && (!r_out_valid || bus.out_ready)) begin
      w_pop = 1'b1;
    end else begin
      w_pop = 1'b0;
    end
    w_rbin_next = r_rbin + {{DEPTH{1'b0}}, w_pop};
    w_rgnext    = b2g(w_rbin_next);
  end

  // Read pointer, empty flag and count, all computed from the post-pop pointer
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_rbin   <= {PW{1'b0}};
      r_rptr   <= {PW{1'b0}};
      r_rempty <= 1'b1;
      r_rcount <= {PW{1'b0}};
    end else begin
      r_rbin   <= w_rbin_next;
      r_rptr   <= w_rgnext;
      r_rempty <= (w_rgnext == w_wsync);
      r_rcount <= g2b(w_wsync) - w_rbin_next;
    end
  end

  // Output register: load on pop, clear valid when the sink takes the last word
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_out_data  <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
    end else if (w_pop) begin
      r_out_data  <= bus.rdata;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_data  <= r_out_data;
      r_out_valid <= 1'b0;
    end else begin
      r_out_data  <= r_out_data;
      r_out_valid <= r_out_valid;
    end
  end

  assign bus.raddr     = r_rbin[DEPTH-1:0];
  assign bus.rptr      = r_rptr;
  assign bus.rempty    = r_rempty;
  assign bus.rcount    = r_rcount;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_fifo_rd_cntrl.sv
// Bench for fifo_rd_cntrl: directed scenarios drive a modelled write side and
// memory; a negedge monitor checks every accepted output word against a queue.
module tb_fifo_rd_cntrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
`ifdef FIFO_RD_SYNC_EN
  localparam int SYNC_EXTRA = 2;
`else
  localparam int SYNC_EXTRA = 0;
`endif

  logic rclk = 1'b0;
  logic rrst;

  always #5 rclk = ~rclk;

  fifo_rd_cntrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fifo_rd_cntrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus)
  );

  logic [7:0] mem [8];
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;
  logic [3:0] wbin;
  int         total = 0;
  int         bad   = 0;

  assign bus.rdata = mem[bus.raddr];

  function automatic logic [3:0] gray(input logic [3:0] b);
    return (b >> 1) ^ b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // advance to just after the next rising edge (input drive point)
  task automatic cyc();
    @(posedge rclk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    mem[wbin[2:0]] = d;
    wbin = wbin + 4'd1;
    bus.rq_wptr = gray(wbin);
    exp_q.push_back(d);
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    bus.rq_wptr = 4'b0110;
    cyc();
    cyc();
    rrst = 1'b0;
    wbin = 4'd0;
    bus.rq_wptr = 4'd0;
    exp_q.delete();
  endtask

  // returns at the first negedge where rempty is low
  task automatic wait_nonempty(input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge rclk);
      if (!bus.rempty) begin
        seen = 1'b1;
        break;
      end
      cyc();
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  // Monitor: every handshake that will complete on the next edge is checked
  always @(negedge rclk) begin
    if (!rrst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL monitor: unexpected word %0h", bus.out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("out_data", {24'd0, bus.out_data}, {24'd0, mon_exp});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rrst = 1'b1;
    bus.out_ready = 1'b0;
    bus.rq_wptr = 4'b0110;
    wbin = 4'd0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;

    // reset with a nonzero write pointer present
    do_reset();
    @(negedge rclk);
    chk("rst_rempty", {31'd0, bus.rempty}, 32'd1);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_rcount", {28'd0, bus.rcount}, 32'd0);
    chk("rst_rptr", {28'd0, bus.rptr}, 32'd0);
    chk("rst_data", {24'd0, bus.out_data}, 32'd0);

    // single word: empty flag latency, one pop, back to empty
    cyc();
    bus.out_ready = 1'b1;
    write_word(8'hA5);
    for (int i = 0; i < 1 + SYNC_EXTRA; i++) begin
      @(negedge rclk);
      chk("lat_still_empty", {31'd0, bus.rempty}, 32'd1);
      cyc();
    end
    @(negedge rclk);
    chk("one_rempty", {31'd0, bus.rempty}, 32'd0);
    chk("one_rcount", {28'd0, bus.rcount}, 32'd1);
    chk("one_valid_pre", {31'd0, bus.out_valid}, 32'd0);
    cyc();
    @(negedge rclk);
    chk("one_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("one_data", {24'd0, bus.out_data}, 32'hA5);
    chk("one_empty_again", {31'd0, bus.rempty}, 32'd1);
    chk("one_rcount0", {28'd0, bus.rcount}, 32'd0);
    chk("one_rptr", {28'd0, bus.rptr}, 32'd1);
    cyc();
    @(negedge rclk);
    chk("one_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    chk("one_no_extra_pop", {28'd0, bus.rptr}, 32'd1);
    cyc();

    // burst: 8 words pre-written, full-rate drain
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) write_word(8'hC0 + 8'(k));
    wait_nonempty("burst_nonempty");
    for (int k = 0; k < 8; k++) begin
      chk("burst_raddr", {29'd0, bus.raddr}, 32'(k));
      chk("burst_rcount", {28'd0, bus.rcount}, 32'(8 - k));
      cyc();
      @(negedge rclk);
    end
    chk("burst_empty", {31'd0, bus.rempty}, 32'd1);
    chk("burst_rcount0", {28'd0, bus.rcount}, 32'd0);
    chk("burst_rptr", {28'd0, bus.rptr}, 32'hC);
    cyc();

    // stall: sink not ready, exactly one pop then everything holds
    do_reset();
    bus.out_ready = 1'b0;
    write_word(8'h11);
    write_word(8'h22);
    write_word(8'h33);
    wait_nonempty("stall_nonempty");
    chk("stall_rcount3", {28'd0, bus.rcount}, 32'd3);
    chk("stall_valid0", {31'd0, bus.out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge rclk);
      chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_data", {24'd0, bus.out_data}, 32'h11);
      chk("stall_rptr", {28'd0, bus.rptr}, 32'd1);
      chk("stall_rcount", {28'd0, bus.rcount}, 32'd2);
    end
    cyc();
    bus.out_ready = 1'b1;
    @(negedge rclk);
    cyc();
    @(negedge rclk);
    chk("accept_and_pop_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("accept_and_pop_data", {24'd0, bus.out_data}, 32'h22);
    cyc();
    @(negedge rclk);
    chk("stall_last_data", {24'd0, bus.out_data}, 32'h33);
    chk("stall_last_empty", {31'd0, bus.rempty}, 32'd1);
    cyc();

    // reset mid-operation discards the held word and unread words
    bus.out_ready = 1'b0;
    write_word(8'h5A);
    write_word(8'h6B);
    wait_nonempty("mid_nonempty");
    cyc();
    do_reset();
    @(negedge rclk);
    chk("mid_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_data", {24'd0, bus.out_data}, 32'd0);
    chk("mid_rempty", {31'd0, bus.rempty}, 32'd1);
    chk("mid_rcount", {28'd0, bus.rcount}, 32'd0);
    chk("mid_rptr", {28'd0, bus.rptr}, 32'd0);
    cyc();

    // wrap: 20 words streamed, pointer passes 15 -> 0
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      write_word(8'h40 + 8'(i));
      cyc();
    end
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) cyc();
    chk("wrap_drained", 32'(exp_q.size()), 32'd0);
    cyc();
    cyc();
    @(negedge rclk);
    chk("wrap_rptr", {28'd0, bus.rptr}, 32'h6);
    chk("wrap_rempty", {31'd0, bus.rempty}, 32'd1);
    chk("wrap_rcount", {28'd0, bus.rcount}, 32'd0);
    chk("wrap_valid", {31'd0, bus.out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
